// File: rtl/md_unit.sv
// Multiply/divide unit with architectural HI/LO registers.
// The result is computed at start into shadow registers and committed after a fixed latency.
module md_unit #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CW = 4;
  localparam int unsigned DW = 32;

  logic [CW-1:0]        count;
  logic [DW-1:0]        shadow_hi;
  logic [DW-1:0]        shadow_lo;
  logic [2*DW-1:0]      result_c;
  logic signed [2*DW-1:0] prod_s_c;
  logic [2*DW-1:0]      prod_u_c;
  logic signed [DW-1:0] quot_s_c;
  logic signed [DW-1:0] rem_s_c;

  // Full 64-bit result for the requested operation, including the MIPS corner cases
  always_comb begin
    prod_s_c = $signed({{DW{rs_val[DW-1]}}, rs_val}) * $signed({{DW{rt_val[DW-1]}}, rt_val});
    prod_u_c = {{DW{1'b0}}, rs_val} * {{DW{1'b0}}, rt_val};
    quot_s_c = '0;
    rem_s_c  = '0;
    result_c = '0;
    if (rs_val == 32'h8000_0000 && rt_val == 32'hFFFF_FFFF) begin
      quot_s_c = $signed(32'h8000_0000);
      rem_s_c  = '0;
    end else if (rt_val != '0) begin
      quot_s_c = $signed(rs_val) / $signed(rt_val);
      rem_s_c  = $signed(rs_val) % $signed(rt_val);
    end
    case (md_op)
      2'b00: result_c = prod_s_c;
      2'b01: result_c = prod_u_c;
      2'b10: result_c = (rt_val == '0) ? {rs_val, 32'hFFFF_FFFF} : {rem_s_c, quot_s_c};
      default: result_c = (rt_val == '0) ? {rs_val, 32'hFFFF_FFFF}
                                         : {rs_val % rt_val, rs_val / rt_val};
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hi        <= '0;
      lo        <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      count     <= '0;
      shadow_hi <= '0;
      shadow_lo <= '0;
    end else begin
      done <= 1'b0;
      if (busy) begin
        // All commands are dropped while an operation is in flight
        count <= count - CW'(1);
        if (count == CW'(1)) begin
          hi   <= shadow_hi;
          lo   <= shadow_lo;
          busy <= 1'b0;
          done <= 1'b1;
        end
      end else if (start) begin
        shadow_hi <= result_c[2*DW-1:DW];
        shadow_lo <= result_c[DW-1:0];
        count     <= md_op[1] ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
        busy      <= 1'b1;
      end else if (mthi) begin
        hi <= rs_val;
      end else if (mtlo) begin
        lo <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_md_unit.sv
// Self-checking bench for md_unit: per-cycle model comparison plus literal expectations.
module tb_md_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  md_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        mthi;
  logic        mtlo;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .md_op(md_op),
    .rs_val(rs_val), .rt_val(rt_val), .mthi(mthi), .mtlo(mtlo),
    .hi(hi), .lo(lo), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference arithmetic done in 64-bit integers
  function automatic logic [63:0] calc(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    logic signed [63:0] q, r;
    sa = $signed(a);
    sb = $signed(b);
    case (op)
      2'd0: return 64'(sa * sb);
      2'd1: return {32'h0, a} * {32'h0, b};
      2'd2: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (b == 0) return {a, 32'hFFFF_FFFF};
        return {a % b, a / b};
      end
    endcase
  endfunction

  // Model: tracks architectural HI/LO and the cycle at which a pending result lands
  logic [31:0] m_hi = '0, m_lo = '0;
  logic [63:0] m_pend = '0;
  logic        m_pending = 1'b0, m_done = 1'b0, m_en = 1'b0;
  int          cyc = 0, m_end = 0;

  always @(posedge clk) begin
    cyc++;
    m_done = 1'b0;
    if (reset) begin
      m_hi = '0; m_lo = '0; m_pending = 1'b0; m_en = 1'b1;
    end else if (m_pending) begin
      if (cyc == m_end) begin
        m_hi = m_pend[63:32]; m_lo = m_pend[31:0];
        m_pending = 1'b0; m_done = 1'b1;
      end
    end else if (start) begin
      m_pend = calc(md_op, rs_val, rt_val);
      m_end = cyc + (md_op[1] ? 10 : 5);
      m_pending = 1'b1;
    end else if (mthi) begin
      m_hi = rs_val;
    end else if (mtlo) begin
      m_lo = rs_val;
    end
  end

  always @(posedge clk) begin
    #1;
    if (m_en) begin
      chk("cyc_hi", hi, m_hi);
      chk("cyc_lo", lo, m_lo);
      chk("cyc_busy", 32'(busy), 32'(m_pending));
      chk("cyc_done", 32'(done), 32'(m_done));
    end
  end

  task automatic wait_done(output int bc);
    int n = 0;
    bc = 0;
    while (done !== 1'b1 && n < 40) begin
      if (busy === 1'b1) bc++;
      @(posedge clk); #1;
      n++;
    end
    chk("done_timeout", 32'(done), 32'd1);
  endtask

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic with_mthi, output int bc);
    @(negedge clk);
    start = 1'b1; md_op = op; rs_val = a; rt_val = b; mthi = with_mthi;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(bc);
  endtask

  initial begin
    int bc;
    logic seen;
    reset = 1'b1; start = 1'b0; md_op = '0; rs_val = '0; rt_val = '0; mthi = 1'b0; mtlo = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    chk("rst_hi", hi, 32'h0);
    chk("rst_lo", lo, 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);

    run_op(2'd0, 32'hFFFF_FFFF, 32'h2, 1'b0, bc);
    chk("mult_busy_cycles", 32'(bc), 32'd5);
    chk("mult_hi", hi, 32'hFFFF_FFFF);
    chk("mult_lo", lo, 32'hFFFF_FFFE);

    run_op(2'd1, 32'hFFFF_FFFF, 32'h2, 1'b0, bc);
    chk("multu_hi", hi, 32'h0000_0001);
    chk("multu_lo", lo, 32'hFFFF_FFFE);

    run_op(2'd2, 32'hFFFF_FFF9, 32'h2, 1'b0, bc);
    chk("div_busy_cycles", 32'(bc), 32'd10);
    chk("div_lo", lo, 32'hFFFF_FFFD);
    chk("div_hi", hi, 32'hFFFF_FFFF);

    run_op(2'd3, 32'd7, 32'd2, 1'b0, bc);
    chk("divu_lo", lo, 32'd3);
    chk("divu_hi", hi, 32'd1);

    run_op(2'd3, 32'h1234_5678, 32'h0, 1'b0, bc);
    chk("divz_lo", lo, 32'hFFFF_FFFF);
    chk("divz_hi", hi, 32'h1234_5678);

    run_op(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, bc);
    chk("divovf_lo", lo, 32'h8000_0000);
    chk("divovf_hi", hi, 32'h0);

    // Commands presented while busy must be ignored
    @(negedge clk);
    start = 1'b1; md_op = 2'd0; rs_val = 32'd3; rt_val = 32'd5;
    @(negedge clk);
    start = 1'b1; md_op = 2'd3; rs_val = 32'hAAAA_0000; rt_val = 32'd3; mthi = 1'b1;
    @(negedge clk);
    start = 1'b0; mthi = 1'b0;
    wait_done(bc);
    chk("busy_ign_hi", hi, 32'h0);
    chk("busy_ign_lo", lo, 32'd15);
    @(negedge clk);
    chk("busy_ign_idle", 32'(busy), 32'h0);

    @(negedge clk);
    mthi = 1'b1; rs_val = 32'h1111_1111;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; rs_val = 32'h2222_2222;
    @(negedge clk);
    mtlo = 1'b0;
    chk("mt_hi", hi, 32'h1111_1111);
    chk("mt_lo", lo, 32'h2222_2222);
    chk("mt_busy", 32'(busy), 32'h0);

    run_op(2'd0, 32'd3, 32'd4, 1'b1, bc);
    chk("start_mthi_hi", hi, 32'h0);
    chk("start_mthi_lo", lo, 32'd12);

    @(negedge clk);
    mthi = 1'b1; mtlo = 1'b1; rs_val = 32'h55;
    @(negedge clk);
    mthi = 1'b0; mtlo = 1'b0;
    chk("both_mt_hi", hi, 32'h55);
    chk("both_mt_lo", lo, 32'd12);

    // Reset during the third busy cycle of a divide
    @(negedge clk);
    start = 1'b1; md_op = 2'd2; rs_val = 32'd100; rt_val = 32'd7;
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_hi", hi, 32'h0);
    chk("midrst_lo", lo, 32'h0);
    seen = 1'b0;
    repeat (15) begin
      @(posedge clk); #1;
      if (done === 1'b1) seen = 1'b1;
    end
    chk("midrst_no_done", 32'(seen), 32'h0);

    // Back-to-back: second start lands in the cycle busy first reads 0
    run_op(2'd1, 32'd6, 32'd7, 1'b0, bc);
    chk("b2b_first_lo", lo, 32'd42);
    run_op(2'd2, 32'hFFFF_FF9C, 32'd7, 1'b0, bc);
    chk("b2b_busy_cycles", 32'(bc), 32'd10);
    chk("b2b_lo", lo, 32'hFFFF_FFF2);
    chk("b2b_hi", hi, 32'hFFFF_FFFE);

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
